cnn_lenet_mul_arb: RTL and testbench
====================================

CNN_LENET_MUL_ARB -- requirements
Module: cnn_lenet_mul_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one multiplier; legal range 2..8.
REQ-002 Parameter A_W, default 4: operand A width, unsigned.
REQ-003 Parameter B_W, default 7: operand B width, unsigned.
REQ-004 Parameter P_W, default 10: product width.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset; ports ap_clk and ap_rst.
REQ-006 ap_clk  in  1  rising-edge clock for all state.
REQ-007 ap_rst  in  1  synchronous active-high reset.
REQ-008 req_valid  in  NUM_REQ  per-requester operand valid.
REQ-009 req_ready  out  NUM_REQ  per-requester grant/accept.
REQ-010 req_a  in  NUM_REQ*A_W  packed operand A, requester i at bits [i*A_W +: A_W].
REQ-011 req_b  in  NUM_REQ*B_W  packed operand B, same packing.
REQ-012 rsp_valid  out  NUM_REQ  per-requester product valid.
REQ-013 rsp_ready  in  NUM_REQ  per-requester product consumed.
REQ-014 rsp_data  out  NUM_REQ*P_W  packed products, requester i at [i*P_W +: P_W].
REQ-015 busy  out  1  high while any operation is in stage 1 or any rsp_valid is high.

Function
REQ-016 Accept handshake: an operation is accepted from requester i in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-017 At most one req_ready bit SHALL be high per cycle; req_ready MAY depend combinationally on req_valid.
REQ-018 Requester i is eligible when req_valid[i]=1 and its outstanding flag is 0.
REQ-019 Outstanding flag i is set on accept and cleared on the rsp_valid[i]&rsp_ready[i] handshake; at most one outstanding op per requester.
REQ-020 Grant SHALL be round-robin: search from pointer ptr upward modulo NUM_REQ; first eligible requester wins.
REQ-021 On grant to i, ptr becomes (i+1) mod NUM_REQ the next cycle; with no grant, ptr is unchanged.
REQ-022 Stage 1: accepted operands and the requester id are registered with a stage-valid bit in the cycle after accept.
REQ-023 The product SHALL be the unsigned product of the zero-extended operands, truncated to its low P_W bits (15*127 yields 881).
REQ-024 The product is written into requester i's response register at the end of the stage-1 cycle; rsp_valid[i] is high two cycles after the accept cycle.
REQ-025 rsp_data[i] and rsp_valid[i] SHALL hold stable until rsp_ready[i] is high.
REQ-026 Throughput SHALL be one accept per cycle across all requesters when distinct requesters are eligible.
REQ-027 The outstanding flag is cleared on the response handshake. A new accept for the same requester is not possible in that same cycle, because eligibility uses the registered flag; the earliest re-accept is the following cycle.
REQ-028 rsp_ready asserted while rsp_valid is low SHALL have no effect.
REQ-029 busy = stage-valid OR any rsp_valid, registered-state derived, no dependence on req_valid.

Reset
REQ-030 On ap_rst=1 at a clock edge: ptr=0, all outstanding flags=0, stage-valid=0, rsp_valid=0, rsp_data=0, busy=0.
REQ-031 Reset mid-operation SHALL discard in-flight and pending products with no rsp_valid pulse afterward.
REQ-032 While ap_rst=1, req_ready SHALL be all-zero.

Structure
REQ-033 The multiply SHALL be one instance of the existing cnn_lenet_mul_4ns_7ns_10_1_1 combinational multiplier, fed from the stage-1 registers; it is the only sub-module.
REQ-034 Default widths and the clog2(NUM_REQ) id width SHALL live in a shared cnn_lenet package; no other typedefs are needed.

Verification
REQ-035 Only req 2 is valid with a=3, b=5 at cycle 0 -> req_ready[2]=1 in cycle 0, rsp_valid[2]=1 with rsp_data=15 in cycle 2.
REQ-036 Requester 0 is valid with a=15, b=127 -> rsp_data[0]=881 (truncation check).
REQ-037 All 4 requesters are valid continuously, rsp_ready tied high, ptr=0 -> grants 0,1,2,3,0,... one per cycle.
REQ-038 Req 1 has a response pending and rsp_ready[1]=0 for 5 cycles while req_valid[1]=1 -> req_ready[1]=0 throughout and rsp_data[1] stays stable; other requesters are still granted.
REQ-039 ap_rst pulsed one cycle after an accept -> no rsp_valid in any later cycle, and ptr restarts at 0.
REQ-040 rsp_ready[3] pulsed with rsp_valid[3]=0 -> no state change; a subsequent accept and response for requester 3 is correct.

Source files
------------

// File: rtl/cnn_lenet_pkg.sv
// Shared defaults for the LeNet multiplier-sharing blocks.
// Provides the default operand/product widths and the requester-id width helper.
package cnn_lenet_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_A_W     = 4;
    localparam int DEF_B_W     = 7;
    localparam int DEF_P_W     = 10;

    // Requester-id width; a single requester still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_lenet_mul_4ns_7ns_10_1_1.sv
// Combinational unsigned multiplier with the product truncated to dout_WIDTH bits.
module cnn_lenet_mul_4ns_7ns_10_1_1 #(
    parameter int din0_WIDTH = 4,
    parameter int din1_WIDTH = 7,
    parameter int dout_WIDTH = 10
) (
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);

    localparam int FW = (din0_WIDTH + din1_WIDTH > dout_WIDTH) ?
                        (din0_WIDTH + din1_WIDTH) : dout_WIDTH;

    logic [FW-1:0] w_a;
    logic [FW-1:0] w_b;

    assign w_a  = FW'(din0);
    assign w_b  = FW'(din1);
    assign dout = dout_WIDTH'(w_a * w_b);

endmodule

// File: rtl/cnn_lenet_mul_arb.sv
// Round-robin arbiter sharing one multiplier among NUM_REQ requesters.
// Accept -> stage-1 operand registers -> per-requester response register (2-cycle latency).
module cnn_lenet_mul_arb
    import cnn_lenet_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int A_W     = DEF_A_W,
    parameter int B_W     = DEF_B_W,
    parameter int P_W     = DEF_P_W
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [NUM_REQ*P_W-1:0] rsp_data,
    output logic                   busy
);

    localparam int ID_W = id_width(NUM_REQ);

    logic [ID_W-1:0]              r_ptr;
    logic [NUM_REQ-1:0]           r_out;
    logic                         r_s1_vld;
    logic [A_W-1:0]               r_s1_a;
    logic [B_W-1:0]               r_s1_b;
    logic [ID_W-1:0]              r_s1_id;
    logic [NUM_REQ-1:0]           r_rsp_vld;
    logic [NUM_REQ-1:0][P_W-1:0]  r_rsp_data;

    logic [NUM_REQ-1:0]           w_elig;
    logic [NUM_REQ-1:0]           w_gnt;
    logic                         w_gnt_any;
    logic [ID_W-1:0]              w_gnt_id;
    logic [ID_W-1:0]              w_ptr_nxt;
    logic [NUM_REQ-1:0]           w_rsp_hs;
    logic [P_W-1:0]               w_prod;

    // Eligibility uses the registered outstanding flag, so a requester whose
    // response handshakes this cycle can only be re-accepted next cycle.
    assign w_elig = req_valid & ~r_out;

    always_comb begin
        int j;
        j         = 0;
        w_gnt     = '0;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_ptr_nxt = r_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!w_gnt_any && w_elig[j]) begin
                w_gnt_any = 1'b1;
                w_gnt[j]  = 1'b1;
                w_gnt_id  = ID_W'(j);
                w_ptr_nxt = (j == NUM_REQ - 1) ? '0 : ID_W'(j + 1);
            end
        end
        if (ap_rst) begin
            w_gnt     = '0;
            w_gnt_any = 1'b0;
        end
    end

    assign req_ready = w_gnt;
    assign w_rsp_hs  = r_rsp_vld & rsp_ready;
    assign rsp_valid = r_rsp_vld;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_s1_vld | (|r_rsp_vld);

    cnn_lenet_mul_4ns_7ns_10_1_1 #(
        .din0_WIDTH (A_W),
        .din1_WIDTH (B_W),
        .dout_WIDTH (P_W)
    ) u_mul (
        .din0 (r_s1_a),
        .din1 (r_s1_b),
        .dout (w_prod)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_ptr    <= '0;
            r_out    <= '0;
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_id  <= '0;
        end else begin
            r_out    <= (r_out & ~w_rsp_hs) | w_gnt;
            r_s1_vld <= w_gnt_any;
            if (w_gnt_any) begin
                r_ptr   <= w_ptr_nxt;
                r_s1_id <= w_gnt_id;
                r_s1_a  <= req_a[int'(w_gnt_id)*A_W +: A_W];
                r_s1_b  <= req_b[int'(w_gnt_id)*B_W +: B_W];
            end
        end
    end

    // A requester's response register is never loaded while it still holds an
    // unconsumed product, since only one op per requester can be outstanding.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_rsp_vld  <= '0;
            r_rsp_data <= '0;
        end else begin
            for (int g = 0; g < NUM_REQ; g++) begin
                if (r_s1_vld && r_s1_id == ID_W'(g)) begin
                    r_rsp_vld[g]  <= 1'b1;
                    r_rsp_data[g] <= w_prod;
                end else if (w_rsp_hs[g]) begin
                    r_rsp_vld[g]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_lenet_mul_arb.sv
// Self-checking bench for cnn_lenet_mul_arb: directed scenarios plus random traffic
// compared against a timestamp-based transaction model.
module tb_cnn_lenet_mul_arb;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int BW = 7;
    localparam int PW = 10;

    logic            ap_clk = 1'b0;
    logic            ap_rst;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic [N*PW-1:0] rsp_data;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    cnn_lenet_mul_arb #(.NUM_REQ(N), .A_W(AW), .B_W(BW), .P_W(PW)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Model: each requester either has no op, or one op whose product becomes
    // visible at cycle m_rdy and stays visible until consumed.
    int            cyc;
    int            m_ptr;
    bit            m_out [N];
    int            m_rdy [N];
    logic [PW-1:0] m_dat [N];
    logic [N-1:0]  exp_ready, exp_rv;
    logic          exp_busy;

    function automatic int get_a(input int i);
        return int'(req_a[i*AW +: AW]);
    endfunction

    function automatic int get_b(input int i);
        return int'(req_b[i*BW +: BW]);
    endfunction

    function automatic logic [PW-1:0] get_d(input int i);
        return rsp_data[i*PW +: PW];
    endfunction

    function automatic void model_eval();
        bit found;
        found     = 0;
        exp_ready = '0;
        exp_rv    = '0;
        exp_busy  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_out[i] && cyc >= m_rdy[i])     exp_rv[i] = 1'b1;
            if (m_out[i] && cyc >= m_rdy[i] - 1) exp_busy  = 1'b1;
        end
        if (ap_rst !== 1'b1) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!found && req_valid[j] === 1'b1 && !m_out[j]) begin
                    found        = 1;
                    exp_ready[j] = 1'b1;
                end
            end
        end
    endfunction

    function automatic void model_commit();
        if (ap_rst === 1'b1) begin
            m_ptr = 0;
            for (int i = 0; i < N; i++) begin
                m_out[i] = 0;
                m_dat[i] = '0;
            end
        end else begin
            for (int i = 0; i < N; i++)
                if (exp_rv[i] && rsp_ready[i] === 1'b1) m_out[i] = 0;
            for (int i = 0; i < N; i++) begin
                if (exp_ready[i]) begin
                    m_out[i] = 1;
                    m_rdy[i] = cyc + 2;
                    m_dat[i] = PW'(get_a(i) * get_b(i));
                    m_ptr    = (i + 1) % N;
                end
            end
        end
        cyc++;
    endfunction

    task automatic set_ops(input int i, input int a, input int b);
        req_a[i*AW +: AW] = AW'(a);
        req_b[i*BW +: BW] = BW'(b);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++)
            set_ops(i, int'($urandom_range(0, (1 << AW) - 1)), int'($urandom_range(0, (1 << BW) - 1)));
    endtask

    task automatic drive(input logic rst, input logic [N-1:0] v, input logic [N-1:0] rr);
        ap_rst    = rst;
        req_valid = v;
        rsp_ready = rr;
        @(negedge ap_clk);
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [N-1:0] rr);
        for (int c = 0; c < n; c++) begin
            drive(1'b0, '0, rr);
            advance();
        end
    endtask

    task automatic test_reset();
        rand_ops();
        drive(1'b1, N'($urandom), N'($urandom));
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=0", req_ready);
        end
        advance();
        drive(1'b0, '0, '0);
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_state got rv=%b busy=%b data=%h exp all zero", rsp_valid, busy, rsp_data);
        end
        advance();
    endtask

    task automatic test_single();
        set_ops(2, 3, 5);
        drive(1'b0, 4'b0100, '0);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant got=%b exp=0100", req_ready);
        end
        advance();
        drive(1'b0, '0, '0);
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_stage1 got rv=%b busy=%b exp rv=0000 busy=1", rsp_valid, busy);
        end
        advance();
        drive(1'b0, '0, '0);
        checks++;
        if (rsp_valid !== 4'b0100 || get_d(2) !== PW'(15)) begin
            errors++;
            $display("FAIL single_rsp got rv=%b data=%0d exp rv=0100 data=15", rsp_valid, get_d(2));
        end
        advance();
        idle(2, 4'b0100);
    endtask

    task automatic test_trunc();
        set_ops(0, 15, 127);
        drive(1'b0, 4'b0001, '0);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL trunc_grant got=%b exp=0001", req_ready);
        end
        advance();
        idle(1, '0);
        drive(1'b0, '0, 4'b0001);
        checks++;
        if (rsp_valid[0] !== 1'b1 || get_d(0) !== PW'(881)) begin
            errors++;
            $display("FAIL trunc_data got rv=%b data=%0d exp rv=1 data=881", rsp_valid[0], get_d(0));
        end
        advance();
        idle(2, '1);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp1;
        drive(1'b1, '0, '0);
        advance();
        for (int k = 0; k < 12; k++) begin
            rand_ops();
            drive(1'b0, '1, '1);
            exp1 = N'(1 << (k % N));
            checks++;
            if (req_ready !== exp1 || {rsp_valid, busy} !== {exp_rv, exp_busy}) begin
                errors++;
                $display("FAIL rr_grant k=%0d got rdy=%b rv=%b busy=%b exp rdy=%b rv=%b busy=%b",
                         k, req_ready, rsp_valid, busy, exp1, exp_rv, exp_busy);
            end
            for (int i = 0; i < N; i++) begin
                if (exp_rv[i]) begin
                    checks++;
                    if (get_d(i) !== m_dat[i]) begin
                        errors++;
                        $display("FAIL rr_data k=%0d req=%0d got=%0d exp=%0d", k, i, get_d(i), m_dat[i]);
                    end
                end
            end
            advance();
        end
        idle(3, '1);
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] hold;
        rand_ops();
        drive(1'b0, 4'b0010, '0);
        advance();
        idle(1, '0);
        hold = m_dat[1];
        for (int c = 0; c < 5; c++) begin
            rand_ops();
            drive(1'b0, '1, 4'b1101);
            checks++;
            if (req_ready[1] !== 1'b0 || req_ready === '0 || req_ready !== exp_ready) begin
                errors++;
                $display("FAIL bp_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready);
            end
            checks++;
            if (rsp_valid[1] !== 1'b1 || get_d(1) !== hold) begin
                errors++;
                $display("FAIL bp_hold c=%0d got rv=%b data=%0d exp rv=1 data=%0d", c, rsp_valid[1], get_d(1), hold);
            end
            advance();
        end
        drive(1'b0, '0, '1);
        advance();
        idle(3, '1);
    endtask

    task automatic test_reset_mid();
        rand_ops();
        drive(1'b0, 4'b0100, '1);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL rstmid_grant got=%b exp=0100", req_ready);
        end
        advance();
        drive(1'b1, '0, '1);
        advance();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, '0, '1);
            checks++;
            if (rsp_valid !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_flush c=%0d got rv=%b busy=%b exp rv=0000 busy=0", c, rsp_valid, busy);
            end
            advance();
        end
        rand_ops();
        drive(1'b0, '1, '1);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_ptr got=%b exp=0001", req_ready);
        end
        advance();
        idle(3, '1);
    endtask

    task automatic test_spurious_ready();
        int a, b;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, '0, 4'b1000);
            checks++;
            if (rsp_valid !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL spur_idle c=%0d got rv=%b busy=%b exp rv=0000 busy=0", c, rsp_valid, busy);
            end
            advance();
        end
        a = int'($urandom_range(1, 15));
        b = int'($urandom_range(1, 127));
        set_ops(3, a, b);
        drive(1'b0, 4'b1000, '0);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL spur_grant got=%b exp=1000", req_ready);
        end
        advance();
        idle(1, '0);
        drive(1'b0, '0, '0);
        checks++;
        if (rsp_valid !== 4'b1000 || get_d(3) !== PW'(a * b)) begin
            errors++;
            $display("FAIL spur_rsp got rv=%b data=%0d exp rv=1000 data=%0d", rsp_valid, get_d(3), PW'(a * b));
        end
        advance();
        drive(1'b0, '0, 4'b1000);
        advance();
        drive(1'b0, '0, '0);
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL spur_drain got rv=%b busy=%b exp rv=0000 busy=0", rsp_valid, busy);
        end
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rand_ops();
            drive(($urandom_range(0, 59) == 0), N'($urandom), N'($urandom));
            checks++;
            if ({req_ready, rsp_valid, busy} !== {exp_ready, exp_rv, exp_busy}) begin
                errors++;
                $display("FAIL rand_ctl c=%0d got rdy=%b rv=%b busy=%b exp rdy=%b rv=%b busy=%b",
                         c, req_ready, rsp_valid, busy, exp_ready, exp_rv, exp_busy);
            end
            for (int i = 0; i < N; i++) begin
                if (exp_rv[i]) begin
                    checks++;
                    if (get_d(i) !== m_dat[i]) begin
                        errors++;
                        $display("FAIL rand_data c=%0d req=%0d got=%0d exp=%0d", c, i, get_d(i), m_dat[i]);
                    end
                end
            end
            advance();
        end
        idle(4, '1);
    endtask

    initial begin
        cyc       = 0;
        m_ptr     = 0;
        ap_rst    = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) begin
            m_out[i] = 0;
            m_rdy[i] = 0;
            m_dat[i] = '0;
        end
        @(posedge ap_clk);
        #1;
        test_reset();
        test_single();
        test_trunc();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_spurious_ready();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
